// File: rtl/bicubic_window_feeder_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_window_feeder_pkg
// Description : Shared constants for the bicubic 4x4 window feeder: default
//               pixel width, window field width, p_u(k) field placement helper
//               and FSM state encodings.
// Revision    : 1.0 - initial release
// ============================================================================
package bicubic_window_feeder_pkg;

    localparam int c_PIX_W      = 8;
    localparam int c_FIELD_W    = c_PIX_W + 1;   // sign bit (always 0) + pixel
    localparam int c_NUM_FIELDS = 16;            // p_u1 .. p_u16

    localparam logic [1:0] c_ST_FILL = 2'd0;     // collecting the first three lines
    localparam logic [1:0] c_ST_RUN  = 2'd1;     // producing windows
    localparam logic [1:0] c_ST_LAST = 2'd2;     // waiting for the final window to drain

    // LSB of field k (k = 4*row + col, i.e. p_u(k+1)) in the packed window.
    function automatic int pu_lsb(input int k, input int field_w);
        return k * field_w;
    endfunction

endpackage
`default_nettype wire

// File: rtl/bicubic_window_feeder_if.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_window_feeder_if
// Description : Pixel-in / window-out handshake bundle for the bicubic window
//               feeder. slave = feeder side, master = environment side.
//               Optional macro BICUBIC_WIN_STATS_EN adds the stall_cnt field.
// Revision    : 1.0 - initial release
// ============================================================================
interface bicubic_window_feeder_if
    import bicubic_window_feeder_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = c_PIX_W
) ();
    localparam int XW = $clog2(IMG_W);
    localparam int YW = $clog2(IMG_H);

    logic                                in_valid;
    logic                                in_ready;
    logic [PIX_W-1:0]                    in_pix;
    logic                                win_valid;
    logic                                win_ready;
    logic [c_NUM_FIELDS*(PIX_W+1)-1:0]   win_pix;
    logic [XW-1:0]                       win_x;
    logic [YW-1:0]                       win_y;
    logic                                frame_done;
`ifdef BICUBIC_WIN_STATS_EN
    logic [15:0]                         stall_cnt;
`endif

    modport slave (
        input  in_valid, in_pix, win_ready,
        output in_ready, win_valid, win_pix, win_x, win_y, frame_done
`ifdef BICUBIC_WIN_STATS_EN
        , output stall_cnt
`endif
    );

    modport master (
        output in_valid, in_pix, win_ready,
        input  in_ready, win_valid, win_pix, win_x, win_y, frame_done
`ifdef BICUBIC_WIN_STATS_EN
        , input stall_cnt
`endif
    );

endinterface
`default_nettype wire

// File: rtl/bicubic_line_buffer.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_line_buffer
// Description : One image line of pixel storage, one synchronous write port
//               and one asynchronous read port. Contents are not reset.
// Revision    : 1.0 - initial release
// ============================================================================
module bicubic_line_buffer #(
    parameter int DEPTH = 64,
    parameter int PIX_W = 8,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [PIX_W-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [PIX_W-1:0] rdata
);
    logic [PIX_W-1:0] r_mem [DEPTH];

    // Store the incoming pixel at its column.
    always_ff @(posedge clk) begin
        if (we) r_mem[waddr] <= wdata;
    end

    assign rdata = r_mem[raddr];

endmodule
`default_nettype wire

// File: rtl/bicubic_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : bicubic_window_feeder
// Description : Buffers three previous lines of a raster stream and emits one
//               4x4 neighbourhood (p_u1..p_u16, 9-bit fields) per accepted
//               pixel once a full window exists.
//               Optional macro BICUBIC_WIN_STATS_EN adds a per-frame stall
//               counter on the interface.
// Revision    : 1.0 - initial release
// ============================================================================
module bicubic_window_feeder
    import bicubic_window_feeder_pkg::*;
#(
    parameter int IMG_W = 64,
    parameter int IMG_H = 64,
    parameter int PIX_W = c_PIX_W
) (
    input  logic clk,
    input  logic rst,
    bicubic_window_feeder_if.slave bus
);
    localparam int FIELD_W = PIX_W + 1;
    localparam int XW      = $clog2(IMG_W);
    localparam int YW      = $clog2(IMG_H);
    localparam logic [XW-1:0] c_X_LAST = XW'(IMG_W - 1);
    localparam logic [YW-1:0] c_Y_LAST = YW'(IMG_H - 1);

    logic [1:0]    r_state;
    logic [XW-1:0] r_x;
    logic [YW-1:0] r_y;
    logic [1:0]    r_wr_sel;      // buffer holding the oldest line; written next
    logic [2:0][3:0][PIX_W-1:0] r_cols;   // last three columns [col][row]
    logic                                r_win_valid;
    logic [c_NUM_FIELDS*FIELD_W-1:0]     r_win_pix;
    logic [XW-1:0]                       r_win_x;
    logic [YW-1:0]                       r_win_y;
    logic                                r_frame_done;

    logic w_in_ready, w_accept, w_emit, w_win_hs, w_x_last, w_y_last;
    logic [PIX_W-1:0]            w_lb_rd [3];
    logic [3:0][PIX_W-1:0]       w_new_col;
    logic [3:0][3:0][PIX_W-1:0]  w_next_cols;
    logic [c_NUM_FIELDS*FIELD_W-1:0] w_next_pix;

    assign w_in_ready = (r_state != c_ST_LAST) && (!r_win_valid || bus.win_ready);
    assign w_accept   = bus.in_valid && w_in_ready;
    assign w_win_hs   = r_win_valid && bus.win_ready;
    assign w_x_last   = (r_x == c_X_LAST);
    assign w_y_last   = (r_y == c_Y_LAST);
    assign w_emit     = w_accept && (r_x >= XW'(3)) && (r_y >= YW'(3));

    generate
        for (genvar i = 0; i < 3; i++) begin : g_lb
            bicubic_line_buffer #(.DEPTH(IMG_W), .PIX_W(PIX_W)) u_lb (
                .clk   (clk),
                .we    (w_accept && (r_wr_sel == 2'(i))),
                .waddr (r_x),
                .wdata (bus.in_pix),
                .raddr (r_x),
                .rdata (w_lb_rd[i])
            );
        end
    endgenerate

    // Assemble the incoming column (oldest line on row 0) and the next window.
    always_comb begin
        w_new_col = '0;
        case (r_wr_sel)
            2'd0:    begin w_new_col[0] = w_lb_rd[0]; w_new_col[1] = w_lb_rd[1]; w_new_col[2] = w_lb_rd[2]; end
            2'd1:    begin w_new_col[0] = w_lb_rd[1]; w_new_col[1] = w_lb_rd[2]; w_new_col[2] = w_lb_rd[0]; end
            default: begin w_new_col[0] = w_lb_rd[2]; w_new_col[1] = w_lb_rd[0]; w_new_col[2] = w_lb_rd[1]; end
        endcase
        w_new_col[3] = bus.in_pix;
        w_next_cols[3]   = w_new_col;
        // Column history restarts at the start of each line.
        w_next_cols[2:0] = (r_x == '0) ? '0 : r_cols;
        w_next_pix = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                w_next_pix[pu_lsb(4*r + c, FIELD_W) +: FIELD_W] = {1'b0, w_next_cols[c][r]};
            end
        end
    end

    // Raster position, line-buffer rotation and frame FSM.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_FILL;
            r_x      <= '0;
            r_y      <= '0;
            r_wr_sel <= 2'd0;
        end else begin
            if (w_accept) begin
                if (w_x_last) begin
                    r_x      <= '0;
                    r_y      <= w_y_last ? '0 : r_y + YW'(1);
                    r_wr_sel <= (r_wr_sel == 2'd2) ? 2'd0 : r_wr_sel + 2'd1;
                end else begin
                    r_x <= r_x + XW'(1);
                end
            end
            case (r_state)
                c_ST_FILL: if (w_accept && w_x_last && (r_y == YW'(2))) r_state <= c_ST_RUN;
                c_ST_RUN:  if (w_accept && w_x_last && w_y_last)        r_state <= c_ST_LAST;
                c_ST_LAST: if (w_win_hs)                                r_state <= c_ST_FILL;
                default:   r_state <= c_ST_FILL;
            endcase
        end
    end

    // Column history and the single output window register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cols      <= '0;
            r_win_valid <= 1'b0;
            r_win_pix   <= '0;
            r_win_x     <= '0;
            r_win_y     <= '0;
        end else begin
            if (w_accept) r_cols <= w_next_cols[3:1];
            if (w_emit) begin
                r_win_valid <= 1'b1;
                r_win_pix   <= w_next_pix;
                r_win_x     <= r_x;
                r_win_y     <= r_y;
            end else if (w_win_hs) begin
                r_win_valid <= 1'b0;
            end
        end
    end

    // Pulse once the final window of the frame has been taken.
    always_ff @(posedge clk) begin
        if (rst) r_frame_done <= 1'b0;
        else     r_frame_done <= (r_state == c_ST_LAST) && w_win_hs;
    end

`ifdef BICUBIC_WIN_STATS_EN
    logic [15:0] r_stall_cnt;

    // Count cycles the downstream held off a valid window, per frame, saturating.
    always_ff @(posedge clk) begin
        if (rst || r_frame_done)
            r_stall_cnt <= '0;
        else if (r_win_valid && !bus.win_ready && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
    end

    assign bus.stall_cnt = r_stall_cnt;
`endif

    assign bus.in_ready   = w_in_ready;
    assign bus.win_valid  = r_win_valid;
    assign bus.win_pix    = r_win_pix;
    assign bus.win_x      = r_win_x;
    assign bus.win_y      = r_win_y;
    assign bus.frame_done = r_frame_done;

endmodule
`default_nettype wire

// File: tb/tb_bicubic_window_feeder.sv
`default_nettype none
// ============================================================================
// Module      : tb_bicubic_window_feeder
// Description : Scoreboard bench for bicubic_window_feeder on a 4x4 and an
//               8x8 instance. Optional macro BICUBIC_WIN_STATS_EN enables the
//               stall counter checks.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bicubic_window_feeder;

    typedef struct {
        logic [143:0] pix;
        int           x;
        int           y;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bicubic_window_feeder_if #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) b4 ();
    bicubic_window_feeder_if #(.IMG_W(8), .IMG_H(8), .PIX_W(8)) b8 ();

    bicubic_window_feeder #(.IMG_W(4), .IMG_H(4), .PIX_W(8)) u_dut4 (.clk(clk), .rst(rst), .bus(b4));
    bicubic_window_feeder #(.IMG_W(8), .IMG_H(8), .PIX_W(8)) u_dut8 (.clk(clk), .rst(rst), .bus(b8));

    exp_t        q4[$];
    exp_t        q8[$];
    logic [7:0]  img [8][8];
    int          n_tests   = 0;
    int          n_fail    = 0;
    int          test_id   = 0;
    int          rdy_mode  = 0;
    int          fd4_cnt   = 0;
    int          fd8_cnt   = 0;
    int          inrdy_low = 0;
    int          acc8      = -1;
    bit          chk_first = 1'b0;

    function automatic logic [143:0] mk_win(input int x, input int y);
        logic [143:0] w;
        w = '0;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                w[9*(4*r+c) +: 9] = {1'b0, img[y-3+r][x-3+c]};
        return w;
    endfunction

    task automatic check(input string name, input logic [143:0] act, input logic [143:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got timeout expected progress", name);
    endtask

    // Downstream ready for the 8x8 instance: always, random or held off.
    always begin
        @(negedge clk);
        case (rdy_mode)
            0:       b8.win_ready = 1'b1;
            1:       b8.win_ready = 1'($urandom_range(0, 1));
            default: b8.win_ready = 1'b0;
        endcase
    end

    // 4x4 monitor: pop and compare each handshaken window.
    always begin : mon4
        exp_t e;
        bit   fd_pend;
        @(negedge clk); #2;
        if (rst) begin
            fd_pend = 1'b0;
        end else begin
            if (fd_pend) begin check("frame_done4", 144'(b4.frame_done), 144'd1); fd_pend = 1'b0; end
            if (b4.frame_done) fd4_cnt++;
            if (b4.win_valid && b4.win_ready) begin
                if (q4.size() == 0) timeout_fail("unexpected_window4");
                else begin
                    e = q4.pop_front();
                    check("win4_pix", b4.win_pix, e.pix);
                    check("win4_x", 144'(b4.win_x), 144'(e.x));
                    check("win4_y", 144'(b4.win_y), 144'(e.y));
                    check("win4_pu1",  144'(b4.win_pix[  0 +: 9]), 144'd0);
                    check("win4_pu4",  144'(b4.win_pix[ 27 +: 9]), 144'd3);
                    check("win4_pu13", 144'(b4.win_pix[108 +: 9]), 144'd12);
                    check("win4_pu16", 144'(b4.win_pix[135 +: 9]), 144'd15);
                    if (e.x == 3 && e.y == 3) fd_pend = 1'b1;
                end
            end
        end
    end

    // 8x8 monitor: scoreboard pops, stall stability and frame_done timing.
    always begin : mon8
        exp_t         e;
        bit           fd_pend;
        bit           stall_prev;
        logic [143:0] stall_pix;
        @(negedge clk); #2;
        if (rst) begin
            fd_pend    = 1'b0;
            stall_prev = 1'b0;
        end else begin
            if (fd_pend) begin check("frame_done8", 144'(b8.frame_done), 144'd1); fd_pend = 1'b0; end
            if (b8.frame_done) fd8_cnt++;
            if (stall_prev && b8.win_valid) check("stall_stable8", b8.win_pix, stall_pix);
            stall_prev = b8.win_valid && !b8.win_ready;
            stall_pix  = b8.win_pix;
            if (stall_prev) check("in_ready_stall8", 144'(b8.in_ready), 144'd0);
            if (test_id == 2 && !b8.in_ready) inrdy_low++;
            if (b8.win_valid && b8.win_ready) begin
                if (q8.size() == 0) timeout_fail("unexpected_window8");
                else begin
                    e = q8.pop_front();
                    check("win8_pix", b8.win_pix, e.pix);
                    check("win8_x", 144'(b8.win_x), 144'(e.x));
                    check("win8_y", 144'(b8.win_y), 144'(e.y));
                    if (e.x == 7 && e.y == 7) fd_pend = 1'b1;
                    if (test_id == 2 && e.x == 5 && e.y == 4) begin
                        check("ramp_5_4_pu1",  144'(b8.win_pix[  0 +: 9]), 144'd10);
                        check("ramp_5_4_pu16", 144'(b8.win_pix[135 +: 9]), 144'd37);
                    end
                    if (chk_first) begin
                        check("restart_pu1",  144'(b8.win_pix[  0 +: 9]), 144'd0);
                        check("restart_pu16", 144'(b8.win_pix[135 +: 9]), 144'd27);
                        chk_first = 1'b0;
                    end
                end
            end
        end
    end

    task automatic send_pix4(input int x, input int y);
        exp_t e;
        int   waitc;
        waitc = 0;
        @(negedge clk);
        b4.in_valid = 1'b1;
        b4.in_pix   = img[y][x];
        #1;
        while (!b4.in_ready && waitc < 200) begin @(negedge clk); #1; waitc++; end
        if (waitc >= 200) timeout_fail("in_ready4_wait");
        else if (x >= 3 && y >= 3) begin
            e.pix = mk_win(x, y); e.x = x; e.y = y;
            q4.push_back(e);
        end
        @(posedge clk); #1;
        b4.in_valid = 1'b0;
    endtask

    task automatic send_pix8(input int x, input int y);
        exp_t e;
        int   waitc;
        waitc = 0;
        @(negedge clk);
        b8.in_valid = 1'b1;
        b8.in_pix   = img[y][x];
        #1;
        while (!b8.in_ready && waitc < 200) begin @(negedge clk); #1; waitc++; end
        if (waitc >= 200) timeout_fail("in_ready8_wait");
        else begin
            if (x >= 3 && y >= 3) begin
                e.pix = mk_win(x, y); e.x = x; e.y = y;
                q8.push_back(e);
            end
            acc8 = y*8 + x;
        end
        @(posedge clk); #1;
        b8.in_valid = 1'b0;
    endtask

    // Send the first n_pix pixels of img in raster order, optionally with idle gaps.
    task automatic send_frame8(input bit gaps, input int n_pix);
        for (int i = 0; i < n_pix; i++) begin
            if (gaps) while ($urandom_range(0, 1) == 1) @(negedge clk);
            send_pix8(i % 8, i / 8);
        end
    endtask

    task automatic drain8();
        int n;
        n = 0;
        while ((q8.size() != 0 || b8.win_valid) && n < 300) begin @(negedge clk); n++; end
        if (n >= 300) timeout_fail("drain8");
        repeat (3) @(negedge clk);
    endtask

    task automatic fill_ramp(input int w);
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                img[y][x] = 8'(y*w + x);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        b4.in_valid = 1'b0; b4.in_pix = '0; b4.win_ready = 1'b1;
        b8.in_valid = 1'b0; b8.in_pix = '0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #2;
        check("rst_in_ready8",   144'(b8.in_ready),   144'd1);
        check("rst_win_valid8",  144'(b8.win_valid),  144'd0);
        check("rst_win_pix8",    b8.win_pix,          144'd0);
        check("rst_win_x8",      144'(b8.win_x),      144'd0);
        check("rst_win_y8",      144'(b8.win_y),      144'd0);
        check("rst_frame_done8", 144'(b8.frame_done), 144'd0);
        check("rst_in_ready4",   144'(b4.in_ready),   144'd1);
        check("rst_win_valid4",  144'(b4.win_valid),  144'd0);
`ifdef BICUBIC_WIN_STATS_EN
        check("rst_stall_cnt8",  144'(b8.stall_cnt),  144'd0);
`endif

        // Smallest image: a single window.
        test_id = 1;
        fill_ramp(4);
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                send_pix4(x, y);
        repeat (6) @(negedge clk);
        check("q4_empty", 144'(q4.size()), 144'd0);

        // Continuous ramp frame.
        test_id = 2;
        fill_ramp(8);
        send_frame8(1'b0, 64);
        drain8();
        check("in_ready_low_cycles", 144'(inrdy_low), 144'd1);

        // Downstream stall for 10 cycles mid-frame.
        test_id = 3;
        acc8 = -1;
        fork
            send_frame8(1'b0, 64);
            begin
                wait (acc8 == 45);
                rdy_mode = 2;
                repeat (11) @(posedge clk);
                rdy_mode = 0;
`ifdef BICUBIC_WIN_STATS_EN
                #1;
                check("stall_cnt_10", 144'(b8.stall_cnt), 144'd10);
`endif
            end
        join
        drain8();
`ifdef BICUBIC_WIN_STATS_EN
        check("stall_cnt_cleared", 144'(b8.stall_cnt), 144'd0);
`endif

        // Random input gaps and random downstream ready over two random frames.
        test_id = 4;
        rdy_mode = 1;
        for (int f = 0; f < 2; f++) begin
            for (int y = 0; y < 8; y++)
                for (int x = 0; x < 8; x++)
                    img[y][x] = 8'($urandom_range(0, 255));
            send_frame8(1'b1, 64);
        end
        drain8();
        rdy_mode = 0;
        repeat (2) @(negedge clk);

        // Abort a frame at (2,5) with reset, then send a fresh frame.
        test_id = 5;
        fill_ramp(8);
        send_frame8(1'b0, 42);
        drain8();
        check("q8_empty_pre_reset", 144'(q8.size()), 144'd0);
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        #2;
        check("midrst_in_ready",  144'(b8.in_ready),  144'd1);
        check("midrst_win_valid", 144'(b8.win_valid), 144'd0);
        chk_first = 1'b1;
        send_frame8(1'b0, 64);
        drain8();
        check("restart_window_seen", 144'(chk_first), 144'd0);

        check("frame_done4_count", 144'(fd4_cnt), 144'd1);
        check("frame_done8_count", 144'(fd8_cnt), 144'd5);
        check("q8_empty_end", 144'(q8.size()), 144'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
